// File: rtl/gv_pkg.sv
// gv_pkg -- shared definitions for the score keeper.
//   Mode encodings driven by the game FSM, the score keeper state enum,
//   and the combo bonus threshold / saturation value.
package gv_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_PLAY   = 3'b100;
  localparam logic [2:0] MODE_FINISH = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A hit scores 2 points once combo (before the hit) reaches this value.
  localparam logic [3:0] COMBO_THRESH = 4'd4;
  localparam logic [3:0] COMBO_MAX    = 4'd15;

endpackage

// File: rtl/bcd2_addsub.sv
// bcd2_addsub -- combinational 2-digit BCD saturating add/subtract.
//   bcd_i [7:0] : input value, [7:4] tens, [3:0] units (valid BCD)
//   add_i [1:0] : amount to add (0..2), ignored when sub_i is set
//   sub_i       : subtract 1, floored at 00
//   bcd_o [7:0] : result, clamped to 00..99
module bcd2_addsub (
  input  logic [7:0] bcd_i,
  input  logic [1:0] add_i,
  input  logic       sub_i,
  output logic [7:0] bcd_o
);

  logic [4:0] units_sum;
  logic [3:0] tens_sum;

  always_comb begin
    bcd_o     = bcd_i;
    units_sum = {1'b0, bcd_i[3:0]} + {3'b000, add_i};
    tens_sum  = bcd_i[7:4];
    if (sub_i) begin
      if (bcd_i[3:0] != 4'd0) begin
        bcd_o = {bcd_i[7:4], bcd_i[3:0] - 4'd1};
      end else if (bcd_i[7:4] != 4'd0) begin
        bcd_o = {bcd_i[7:4] - 4'd1, 4'd9};
      end else begin
        bcd_o = 8'h00;
      end
    end else begin
      if (units_sum > 5'd9) begin
        units_sum = units_sum - 5'd10;
        tens_sum  = bcd_i[7:4] + 4'd1;
      end
      // Tens overflowing past 9 means the sum exceeded 99: clamp.
      if (tens_sum > 4'd9) begin
        bcd_o = 8'h99;
      end else begin
        bcd_o = {tens_sum, units_sum[3:0]};
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper -- rhythm game score / hit / miss / combo counter.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   mode  [2:0]  : game mode (IDLE/PLAY/FINISH, other values = IDLE)
//   hit, miss    : one-cycle judgement strobes
//   score [7:0]  : 2-digit BCD score, saturating at 99
//   hits  [7:0]  : 2-digit BCD hit count, saturating at 99
//   misses[7:0]  : 2-digit BCD miss count, saturating at 99
//   combo [3:0]  : consecutive hits, binary, saturating at 15
//   busy         : high while in RUN
// Build option: define SCORE_MISS_PENALTY_EN to make a lone miss subtract
// one point (floored at 00).
//
// state | meaning
// IDLE  | counters held, strobes ignored
// RUN   | counting hits / misses
// DONE  | counters frozen for the high-score stage
module score_keeper
  import gv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score,
  output logic [7:0] hits,
  output logic [7:0] misses,
  output logic [3:0] combo,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] hits_q, hits_d;
  logic [7:0] misses_q, misses_d;
  logic [3:0] combo_q, combo_d;
  logic       busy_q, busy_d;

  logic       is_play, is_finish;
  logic       entering, counting;
  logic [1:0] score_add;
  logic       score_sub;
  logic [7:0] score_nxt, hits_nxt, misses_nxt;

  assign is_play   = (mode == MODE_PLAY);
  assign is_finish = (mode == MODE_FINISH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (is_play) state_d = ST_RUN;
      ST_RUN: begin
        if (is_finish)     state_d = ST_DONE;
        else if (!is_play) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (is_play)         state_d = ST_RUN;
        else if (!is_finish) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry into RUN clears the counters; strobes that cycle are dropped
  // because counting requires the current state to already be RUN.
  assign entering = (state_q != ST_RUN) && (state_d == ST_RUN);
  assign counting = (state_q == ST_RUN);

  // Points only for a lone hit; hit+miss together scores nothing.
  assign score_add = (counting && hit && !miss) ?
                     ((combo_q >= COMBO_THRESH) ? 2'd2 : 2'd1) : 2'd0;

`ifdef SCORE_MISS_PENALTY_EN
  assign score_sub = counting && miss && !hit;
`else
  assign score_sub = 1'b0;
`endif

  bcd2_addsub u_score_as (
    .bcd_i (score_q),
    .add_i (score_add),
    .sub_i (score_sub),
    .bcd_o (score_nxt)
  );

  bcd2_addsub u_hits_as (
    .bcd_i (hits_q),
    .add_i ({1'b0, counting && hit}),
    .sub_i (1'b0),
    .bcd_o (hits_nxt)
  );

  bcd2_addsub u_misses_as (
    .bcd_i (misses_q),
    .add_i ({1'b0, counting && miss}),
    .sub_i (1'b0),
    .bcd_o (misses_nxt)
  );

  always_comb begin
    // Outside RUN every adder sees +0, so *_nxt equals the held value.
    score_d  = score_nxt;
    hits_d   = hits_nxt;
    misses_d = misses_nxt;
    combo_d  = combo_q;
    if (entering) begin
      score_d  = 8'h00;
      hits_d   = 8'h00;
      misses_d = 8'h00;
      combo_d  = 4'd0;
    end else if (counting) begin
      if (miss) begin
        combo_d = 4'd0;
      end else if (hit && (combo_q != COMBO_MAX)) begin
        combo_d = combo_q + 4'd1;
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      score_q  <= 8'h00;
      hits_q   <= 8'h00;
      misses_q <= 8'h00;
      combo_q  <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      combo_q  <= combo_d;
      busy_q   <= busy_d;
    end
  end

  assign score  = score_q;
  assign hits   = hits_q;
  assign misses = misses_q;
  assign combo  = combo_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam logic [2:0] M_IDLE = 3'b000;
  localparam logic [2:0] M_PLAY = 3'b100;
  localparam logic [2:0] M_FIN  = 3'b101;

`ifdef SCORE_MISS_PENALTY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       hit, miss;
  logic [7:0] score, hits, misses;
  logic [3:0] combo;
  logic       busy;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .hit    (hit),
    .miss   (miss),
    .score  (score),
    .hits   (hits),
    .misses (misses),
    .combo  (combo),
    .busy   (busy)
  );

  int tests    = 0;
  int failures = 0;

  // Reference model: plain integers, game phase 0=idle 1=running 2=done.
  int m_phase  = 0;
  int m_score  = 0;
  int m_hits   = 0;
  int m_misses = 0;
  int m_combo  = 0;

  typedef struct {
    bit         rst;
    logic [2:0] mode;
    bit         hit;
    bit         miss;
    int         score;
    int         hits;
    int         misses;
    int         combo;
    bit         busy;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_clear();
    m_score = 0; m_hits = 0; m_misses = 0; m_combo = 0;
  endfunction

  function automatic void model_step(bit r, logic [2:0] md, bit h, bit ms);
    bit play, fin;
    play = (md == M_PLAY);
    fin  = (md == M_FIN);
    if (r) begin
      m_phase = 0;
      model_clear();
      return;
    end
    if (m_phase == 1) begin
      if (h && ms) begin
        m_hits   = min_i(m_hits + 1, 99);
        m_misses = min_i(m_misses + 1, 99);
        m_combo  = 0;
      end else if (h) begin
        m_score = min_i(m_score + ((m_combo >= 4) ? 2 : 1), 99);
        m_hits  = min_i(m_hits + 1, 99);
        m_combo = min_i(m_combo + 1, 15);
      end else if (ms) begin
        m_misses = min_i(m_misses + 1, 99);
        m_combo  = 0;
        if (P == 1 && m_score > 0) m_score = m_score - 1;
      end
      m_phase = play ? 1 : (fin ? 2 : 0);
    end else if (play) begin
      m_phase = 1;
      model_clear();
    end else if (m_phase == 2 && !fin) begin
      m_phase = 0;
    end
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, logic [2:0] md, bit h, bit ms);
    rst  = r;
    mode = md;
    hit  = h;
    miss = ms;
    model_step(r, md, h, ms);
    @(posedge clk);
    #1;
    check("model_score",  score,  to_bcd(m_score));
    check("model_hits",   hits,   to_bcd(m_hits));
    check("model_misses", misses, to_bcd(m_misses));
    check("model_combo",  {4'd0, combo}, 8'(m_combo));
    check("model_busy",   {7'd0, busy},  (m_phase == 1) ? 8'd1 : 8'd0);
  endtask

  task automatic add_vec(bit r, logic [2:0] md, bit h, bit ms,
                         int s, int hh, int mm, int c, bit b);
    vq.push_back('{r, md, h, ms, s, hh, mm, c, b});
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = M_IDLE; hit = 1'b0; miss = 1'b0;

    // Directed table: six-hit game, then 4 hits / miss / hit, hit+miss at
    // combo 3, abort via unknown mode, strobes ignored outside RUN.
    add_vec(1, M_IDLE, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, M_PLAY, 1, 0, 0, 0, 0, 0, 1);
    add_vec(0, M_PLAY, 1, 0, 1, 1, 0, 1, 1);
    add_vec(0, M_PLAY, 1, 0, 2, 2, 0, 2, 1);
    add_vec(0, M_PLAY, 1, 0, 3, 3, 0, 3, 1);
    add_vec(0, M_PLAY, 1, 0, 4, 4, 0, 4, 1);
    add_vec(0, M_PLAY, 1, 0, 6, 5, 0, 5, 1);
    add_vec(0, M_PLAY, 1, 0, 8, 6, 0, 6, 1);
    add_vec(0, M_FIN,  0, 0, 8, 6, 0, 6, 0);
    add_vec(0, M_PLAY, 0, 0, 0, 0, 0, 0, 1);
    add_vec(0, M_PLAY, 1, 0, 1, 1, 0, 1, 1);
    add_vec(0, M_PLAY, 1, 0, 2, 2, 0, 2, 1);
    add_vec(0, M_PLAY, 1, 0, 3, 3, 0, 3, 1);
    add_vec(0, M_PLAY, 1, 0, 4, 4, 0, 4, 1);
    add_vec(0, M_PLAY, 0, 1, 4 - P, 4, 1, 0, 1);
    add_vec(0, M_PLAY, 1, 0, 5 - P, 5, 1, 1, 1);
    add_vec(0, M_PLAY, 1, 0, 6 - P, 6, 1, 2, 1);
    add_vec(0, M_PLAY, 1, 0, 7 - P, 7, 1, 3, 1);
    add_vec(0, M_PLAY, 1, 1, 7 - P, 8, 2, 0, 1);
    add_vec(0, 3'b111, 0, 0, 7 - P, 8, 2, 0, 0);
    add_vec(0, 3'b111, 1, 0, 7 - P, 8, 2, 0, 0);
    add_vec(0, M_FIN,  1, 0, 7 - P, 8, 2, 0, 0);
    add_vec(0, M_IDLE, 0, 1, 7 - P, 8, 2, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].mode, vq[i].hit, vq[i].miss);
      check($sformatf("vec%0d_score", i),  score,  to_bcd(vq[i].score));
      check($sformatf("vec%0d_hits", i),   hits,   to_bcd(vq[i].hits));
      check($sformatf("vec%0d_misses", i), misses, to_bcd(vq[i].misses));
      check($sformatf("vec%0d_combo", i),  {4'd0, combo}, 8'(vq[i].combo));
      check($sformatf("vec%0d_busy", i),   {7'd0, busy},  {7'd0, vq[i].busy});
    end

    // Saturation: score 98 -> 99 -> 99, then hits and misses to 99.
    drive(0, M_IDLE, 0, 0);
    drive(0, M_PLAY, 0, 0);
    for (int i = 0; i < 200 && m_score < 98; i++) drive(0, M_PLAY, 1, 0);
    check("sat_score98", score, 8'h98);
    check("sat_combo_ge4", (combo >= 4'd4) ? 8'd1 : 8'd0, 8'd1);
    drive(0, M_PLAY, 1, 0);
    check("sat_score99", score, 8'h99);
    check("sat_hits52", hits, 8'h52);
    drive(0, M_PLAY, 1, 0);
    check("sat_score_hold", score, 8'h99);
    check("sat_hits53", hits, 8'h53);
    for (int i = 0; i < 60 && m_hits < 99; i++) drive(0, M_PLAY, 1, 0);
    drive(0, M_PLAY, 1, 0);
    check("sat_hits99", hits, 8'h99);
    check("sat_combo15", {4'd0, combo}, 8'd15);
    for (int i = 0; i < 100; i++) drive(0, M_PLAY, 0, 1);
    check("sat_misses99", misses, 8'h99);
    check("sat_score_after_misses", score, (P == 1) ? 8'h00 : 8'h99);

    // Freeze in DONE, then restart clears everything.
    drive(0, M_IDLE, 0, 0);
    drive(0, M_PLAY, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, M_PLAY, 1, 0);
    drive(0, M_FIN, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, M_FIN, 1, 0);
    check("done_score", score, 8'h03);
    check("done_hits", hits, 8'h03);
    check("done_busy", {7'd0, busy}, 8'd0);
    drive(0, M_PLAY, 1, 0);
    check("restart_score", score, 8'h00);
    check("restart_hits", hits, 8'h00);
    check("restart_busy", {7'd0, busy}, 8'd1);

    // Reset mid-game at score 37.
    for (int i = 0; i < 60 && m_score < 34; i++) drive(0, M_PLAY, 1, 0);
    drive(0, M_PLAY, 0, 1);
    for (int i = 0; i < 10 && m_score < 37; i++) drive(0, M_PLAY, 1, 0);
    check("pre_rst_score37", score, 8'h37);
    drive(1, M_PLAY, 1, 0);
    check("rst_score", score, 8'h00);
    check("rst_hits", hits, 8'h00);
    check("rst_combo", {4'd0, combo}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    drive(0, M_IDLE, 1, 0);
    check("post_rst_idle_hits", hits, 8'h00);
    drive(0, M_PLAY, 1, 0);
    check("post_rst_entry_hits", hits, 8'h00);
    drive(0, M_PLAY, 1, 0);
    check("post_rst_count_hits", hits, 8'h01);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [2:0] md;
      bit r;
      sel = int'($urandom_range(0, 19));
      if (sel < 14)       md = M_PLAY;
      else if (sel < 17)  md = M_FIN;
      else if (sel < 18)  md = M_IDLE;
      else                md = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 299) == 0);
      drive(r, md, ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 mode  input  3  game mode from the game FSM: IDLE=3'b000, PLAY=3'b100, FINISH=3'b101; any other value is treated as IDLE.
REQ-005 hit  input  1  one-cycle pulse: note judged a hit.
REQ-006 miss  input  1  one-cycle pulse: note judged a miss.
REQ-007 score  output  8  2-digit BCD score, [7:4] tens and [3:0] units, range 00-99.
REQ-008 hits  output  8  2-digit BCD hit count, 00-99.
REQ-009 misses  output  8  2-digit BCD miss count, 00-99.
REQ-010 combo  output  4  consecutive-hit count, binary, saturates at 15.
REQ-011 busy  output  1  high while in RUN.

Function
REQ-012 The FSM SHALL have three states:
  - IDLE: counters held.
  - RUN: counting.
  - DONE: counters frozen for the downstream high-score stage.
REQ-013 Transitions:
  - IDLE->RUN when mode==PLAY.
  - RUN->DONE when mode==FINISH.
  - RUN->IDLE when mode is any other value (abort).
  - DONE->RUN when mode==PLAY.
  - DONE->IDLE when mode==IDLE.
REQ-014 On every entry into RUN, score, hits, misses and combo SHALL clear to zero in that same cycle, and strobes in that cycle SHALL be ignored.
REQ-015 hit and miss SHALL be counted only while the state is RUN and no entry into RUN is occurring; they SHALL be ignored in IDLE and DONE.
REQ-016 All outputs SHALL be registered; the effect of a strobe in cycle N SHALL be visible in cycle N+1.
REQ-017 A hit alone SHALL:
  - increment hits;
  - add the points value to score (1 if combo before the hit is <4, 2 if >=4);
  - increment combo.
REQ-018 A miss alone SHALL increment misses and clear combo to 0.
REQ-019 hit and miss in the same cycle SHALL increment both hits and misses, add no points, and clear combo.
REQ-020 Every BCD count SHALL saturate at 99; an addition that would exceed 99 yields 99 (e.g. 98+2=99).
REQ-021 Every BCD digit output SHALL always be in the range 0-9.
REQ-022 combo SHALL saturate at 15.
REQ-023 busy SHALL be 1 exactly when the state is RUN.
REQ-024 In DONE, all outputs SHALL hold their last RUN values indefinitely.

Reset
REQ-025 On rst=1 at a clock edge, the state SHALL become IDLE and score, hits, misses, combo and busy SHALL become 0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-game; after release, a new game starts only through a new IDLE->RUN entry.

Configuration
REQ-027 Macro SCORE_MISS_PENALTY_EN:
  - Defined: a lone miss (REQ-018) also subtracts 1 from score, floored at 00; simultaneous hit+miss still leaves score unchanged.
  - Undefined: misses never change score.

Structure
REQ-028 Package gv_pkg SHALL hold:
  - the mode encodings (IDLE, PLAY, FINISH);
  - the FSM state enum typedef;
  - the combo threshold (4) and combo maximum (15).
REQ-029 One sub-module, bcd2_addsub, SHALL implement 2-digit BCD saturating add/subtract (+0..+2, -1) with a floor of 00 and a ceiling of 99; it is instantiated for score, hits and misses.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - mode IDLE->PLAY, 6 hits one cycle apart -> hits=06, combo=6, score=08 (1+1+1+1+2+2).
  - In RUN: 4 hits, 1 miss, 1 hit -> hits=05, misses=01, combo=1, score=05 (penalty off) / 04 (penalty on).
  - hit and miss in the same cycle with combo=3 -> hits+1, misses+1, combo=0, score unchanged.
  - score=98, combo>=4, one hit -> score=99; a further hit keeps score=99 and increments hits.
  - mode PLAY->FINISH then hit pulses -> outputs frozen, busy=0; FINISH->PLAY -> all outputs read 0 in the next cycle.
  - rst asserted mid-RUN with score=37 -> next cycle all outputs 0, state IDLE; hits ignored until mode==PLAY is re-entered.
